// File: rtl/mpp_pkg.sv
// rtl/mpp_pkg.sv - shared sample width, FSM state type and default constants
package mpp_pkg;
  localparam int SAMPLE_W       = 24;
  localparam int DEFAULT_WINDOW = 17;
  localparam int DEFAULT_THRESH = 20000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;
endpackage

// File: rtl/mpp_abs24.sv
// rtl/mpp_abs24.sv - combinational signed-24 to unsigned-24 magnitude
module mpp_abs24
  import mpp_pkg::*;
(
  input  logic signed [SAMPLE_W-1:0] x_i,
  output logic        [SAMPLE_W-1:0] mag_o
);
  // Negating -2^23 wraps to 24'h800000, which read as unsigned is exactly 2^23.
  assign mag_o = x_i[SAMPLE_W-1] ? (~x_i + SAMPLE_W'(1)) : x_i;
endmodule

// File: rtl/mpp_ring_detector.sv
// rtl/mpp_ring_detector.sv - windowed sum/abs-sum/extreme analysis of ring-generator samples
module mpp_ring_detector
  import mpp_pkg::*;
#(
  parameter int WINDOW = DEFAULT_WINDOW,
  parameter int SUM_W  = 32,
  parameter int THRESH = DEFAULT_THRESH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic                       clear,
  output logic signed [SUM_W-1:0]    win_sum,
  output logic        [SUM_W-1:0]    win_abs,
  output logic signed [SAMPLE_W-1:0] win_max,
  output logic signed [SAMPLE_W-1:0] win_min,
  output logic                       result_valid,
  output logic                       detect,
  output logic        [15:0]         win_count
);
  localparam int               IDX_W    = $clog2(WINDOW + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW);
  localparam logic [SUM_W-1:0] THRESH_V = SUM_W'(THRESH);

  state_e                     state_q, state_d;
  logic        [IDX_W-1:0]    idx_q, idx_d;
  logic signed [SUM_W-1:0]    sum_q, sum_d;
  logic        [SUM_W-1:0]    abs_q, abs_d;
  logic signed [SAMPLE_W-1:0] max_q, max_d, min_q, min_d;

  logic signed [SUM_W-1:0]    win_sum_q, win_sum_d;
  logic        [SUM_W-1:0]    win_abs_q, win_abs_d;
  logic signed [SAMPLE_W-1:0] win_max_q, win_max_d, win_min_q, win_min_d;
  logic                       rv_q, rv_d, det_q, det_d;
  logic        [15:0]         cnt_q, cnt_d;

  logic        [SAMPLE_W-1:0] mag;
  logic signed [SUM_W-1:0]    x_ext;
  logic        [SUM_W-1:0]    mag_ext;
  logic                       first;
  logic signed [SUM_W-1:0]    sum_new;
  logic        [SUM_W-1:0]    abs_new;
  logic signed [SAMPLE_W-1:0] max_new, min_new;
  logic        [IDX_W-1:0]    idx_new;

  mpp_abs24 u_abs (
    .x_i  (sample_in),
    .mag_o(mag)
  );

  assign x_ext   = {{(SUM_W-SAMPLE_W){sample_in[SAMPLE_W-1]}}, sample_in};
  assign mag_ext = {{(SUM_W-SAMPLE_W){1'b0}}, mag};

  // In IDLE the incoming sample seeds the accumulators instead of adding to them.
  assign first   = (state_q == ST_IDLE);
  assign sum_new = (first ? '0 : sum_q) + x_ext;
  assign abs_new = (first ? '0 : abs_q) + mag_ext;
  assign max_new = (first || sample_in > max_q) ? sample_in : max_q;
  assign min_new = (first || sample_in < min_q) ? sample_in : min_q;
  assign idx_new = (first ? '0 : idx_q) + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    abs_d     = abs_q;
    max_d     = max_q;
    min_d     = min_q;
    win_sum_d = win_sum_q;
    win_abs_d = win_abs_q;
    win_max_d = win_max_q;
    win_min_d = win_min_q;
    det_d     = det_q;
    cnt_d     = cnt_q;
    rv_d      = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      sum_d   = '0;
      abs_d   = '0;
      max_d   = '0;
      min_d   = '0;
    end else if (sample_valid) begin
      if (idx_new == IDX_LAST) begin
        state_d   = ST_IDLE;
        idx_d     = '0;
        sum_d     = '0;
        abs_d     = '0;
        max_d     = '0;
        min_d     = '0;
        win_sum_d = sum_new;
        win_abs_d = abs_new;
        win_max_d = max_new;
        win_min_d = min_new;
        det_d     = (abs_new >= THRESH_V);
        cnt_d     = cnt_q + 16'd1;
        rv_d      = 1'b1;
      end else begin
        state_d = ST_ACCUM;
        idx_d   = idx_new;
        sum_d   = sum_new;
        abs_d   = abs_new;
        max_d   = max_new;
        min_d   = min_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      sum_q     <= '0;
      abs_q     <= '0;
      max_q     <= '0;
      min_q     <= '0;
      win_sum_q <= '0;
      win_abs_q <= '0;
      win_max_q <= '0;
      win_min_q <= '0;
      det_q     <= 1'b0;
      cnt_q     <= '0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      abs_q     <= abs_d;
      max_q     <= max_d;
      min_q     <= min_d;
      win_sum_q <= win_sum_d;
      win_abs_q <= win_abs_d;
      win_max_q <= win_max_d;
      win_min_q <= win_min_d;
      det_q     <= det_d;
      cnt_q     <= cnt_d;
      rv_q      <= rv_d;
    end
  end

  assign win_sum      = win_sum_q;
  assign win_abs      = win_abs_q;
  assign win_max      = win_max_q;
  assign win_min      = win_min_q;
  assign detect       = det_q;
  assign win_count    = cnt_q;
  assign result_valid = rv_q;
endmodule

// File: tb/tb_mpp_ring_detector.sv
// tb/tb_mpp_ring_detector.sv - self-checking bench for mpp_ring_detector
module tb_mpp_ring_detector;
  localparam int WINDOW = 17;
  localparam int THRESH = 20000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [23:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic               clear = 1'b0;
  logic signed [31:0] win_sum;
  logic        [31:0] win_abs;
  logic signed [23:0] win_max, win_min;
  logic               result_valid, detect;
  logic        [15:0] win_count;

  mpp_ring_detector #(.WINDOW(WINDOW), .SUM_W(32), .THRESH(THRESH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .clear       (clear),
    .win_sum     (win_sum),
    .win_abs     (win_abs),
    .win_max     (win_max),
    .win_min     (win_min),
    .result_valid(result_valid),
    .detect      (detect),
    .win_count   (win_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int obs_q[$];
  always @(negedge clk) if (result_valid === 1'b1) obs_q.push_back(cyc);

  int errors = 0;
  int checks = 0;

  // Reference model: the open window is just the list of accepted samples.
  longint             win_samples[$];
  int                 exp_q[$];
  logic signed [31:0] e_sum = '0;
  logic        [31:0] e_abs = '0;
  logic signed [23:0] e_max = '0, e_min = '0;
  logic               e_det = 1'b0;
  logic        [15:0] e_cnt = '0;

  int hf [17] = '{1920, 1920, 1920, 1920, 1920, 1920,
                  -1920, -1920, -1920, -1920, -1920, -1920,
                  -1583, 800, 0, -801, 1583};

  task automatic finish_window();
    longint s = 0, a = 0, mx, mn;
    mx = win_samples[0];
    mn = win_samples[0];
    foreach (win_samples[i]) begin
      s += win_samples[i];
      a += (win_samples[i] < 0) ? -win_samples[i] : win_samples[i];
      if (win_samples[i] > mx) mx = win_samples[i];
      if (win_samples[i] < mn) mn = win_samples[i];
    end
    e_sum = s[31:0];
    e_abs = a[31:0];
    e_max = mx[23:0];
    e_min = mn[23:0];
    e_det = (a >= THRESH);
    e_cnt = e_cnt + 16'd1;
    win_samples.delete();
  endtask

  task automatic drive(input logic signed [23:0] x, input logic v, input logic c);
    sample_in = x;
    sample_valid = v;
    clear = c;
    @(posedge clk);
    #1;
    if (c) win_samples.delete();
    else if (v) begin
      win_samples.push_back(longint'(x));
      if (win_samples.size() == WINDOW) begin
        finish_window();
        exp_q.push_back(cyc);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0);
  endtask

  task automatic start_scenario();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({win_sum, win_abs, win_max, win_min, result_valid, detect, win_count} !== '0)
      begin errors++; $display("FAIL reset_outputs: got sum=%0d abs=%0d max=%0d min=%0d rv=%b det=%b cnt=%0d, expected all 0",
        win_sum, win_abs, win_max, win_min, result_valid, detect, win_count); end
    rst_n = 1'b1;
    idle(2);
    checks++;
    if ({win_sum, win_abs, win_max, win_min, result_valid, detect, win_count} !== '0)
      begin errors++; $display("FAIL reset_release_idle: outputs changed without samples, cnt=%0d rv=%b", win_count, result_valid); end
  endtask

  task automatic test_hf_pattern();
    start_scenario();
    for (int i = 0; i < 17; i++) drive(24'(hf[i]), 1'b1, 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL hf_pulse_count: got %0d expected 1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0] != exp_q[0]) begin errors++; $display("FAIL hf_pulse_cycle: got %0d expected %0d", obs_q[0], exp_q[0]); end
    end
    checks++;
    if (win_sum !== -32'sd1 || win_abs !== 32'd27807 || win_max !== 24'sd1920 || win_min !== -24'sd1920 ||
        detect !== 1'b1 || win_count !== 16'd1)
      begin errors++; $display("FAIL hf_values: got sum=%0d abs=%0d max=%0d min=%0d det=%b cnt=%0d expected -1 27807 1920 -1920 1 1",
        win_sum, win_abs, win_max, win_min, detect, win_count); end
    checks++;
    if ({win_sum, win_abs, win_max, win_min, detect, win_count} !== {e_sum, e_abs, e_max, e_min, e_det, e_cnt})
      begin errors++; $display("FAIL hf_model: got sum=%0d abs=%0d expected sum=%0d abs=%0d", win_sum, win_abs, e_sum, e_abs); end
  endtask

  task automatic test_gap();
    int first_cyc;
    start_scenario();
    for (int i = 0; i < 17; i++) begin
      drive(24'(hf[i]), 1'b1, 1'b0);
      if (i == 0) first_cyc = cyc;
      if (i == 7) idle(5);
    end
    idle(2);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL gap_pulse_count: got %0d expected 1", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[0] != first_cyc + 21) begin errors++; $display("FAIL gap_pulse_cycle: got %0d expected %0d", obs_q[0], first_cyc + 21); end
    end
    checks++;
    if (win_sum !== -32'sd1 || win_abs !== 32'd27807 || win_count !== 16'd2 ||
        {win_max, win_min, detect} !== {e_max, e_min, e_det})
      begin errors++; $display("FAIL gap_values: got sum=%0d abs=%0d cnt=%0d expected -1 27807 2", win_sum, win_abs, win_count); end
  endtask

  task automatic test_back_to_back();
    start_scenario();
    for (int i = 0; i < 34; i++) drive(24'(hf[i % 17]), 1'b1, 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 2", obs_q.size()); end
    else begin
      checks++;
      if (obs_q[1] - obs_q[0] != 17) begin errors++; $display("FAIL b2b_spacing: got %0d expected 17", obs_q[1] - obs_q[0]); end
      checks++;
      if (obs_q[0] != exp_q[0] || obs_q[1] != exp_q[1]) begin errors++; $display("FAIL b2b_pulse_cycle: got %0d,%0d expected %0d,%0d", obs_q[0], obs_q[1], exp_q[0], exp_q[1]); end
    end
    checks++;
    if (win_sum !== -32'sd1 || win_abs !== 32'd27807 || win_count !== 16'd4)
      begin errors++; $display("FAIL b2b_values: got sum=%0d abs=%0d cnt=%0d expected -1 27807 4", win_sum, win_abs, win_count); end
  endtask

  task automatic test_extremes();
    start_scenario();
    for (int i = 0; i < 17; i++) drive(24'sd100, 1'b1, 1'b0);
    idle(2);
    checks++;
    if (win_sum !== 32'sd1700 || win_abs !== 32'd1700 || detect !== 1'b0 || win_max !== 24'sd100 || win_min !== 24'sd100)
      begin errors++; $display("FAIL small_values: got sum=%0d abs=%0d det=%b expected 1700 1700 0", win_sum, win_abs, detect); end
    for (int i = 0; i < 17; i++) drive(24'h800000, 1'b1, 1'b0);
    idle(2);
    checks++;
    if (win_sum !== -32'sd142606336 || win_abs !== 32'd142606336 || win_max !== 24'h800000 ||
        win_min !== 24'h800000 || detect !== 1'b1)
      begin errors++; $display("FAIL negmax_values: got sum=%0d abs=%0d max=%0d min=%0d det=%b expected -142606336 142606336 -8388608 -8388608 1",
        win_sum, win_abs, win_max, win_min, detect); end
    checks++;
    if (obs_q.size() != 2 || win_count !== e_cnt) begin errors++; $display("FAIL extremes_pulses: got %0d pulses cnt=%0d expected 2 cnt=%0d", obs_q.size(), win_count, e_cnt); end
  endtask

  task automatic test_clear();
    start_scenario();
    for (int i = 0; i < 10; i++) drive(24'(int'($urandom_range(0, 60000)) - 30000), 1'b1, 1'b0);
    drive('0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) drive(24'(hf[i]), 1'b1, 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL clear_pulse_count: got %0d expected 1", obs_q.size()); end
    checks++;
    if (win_sum !== -32'sd1 || win_abs !== 32'd27807 || win_count !== e_cnt)
      begin errors++; $display("FAIL clear_values: got sum=%0d abs=%0d cnt=%0d expected -1 27807 %0d", win_sum, win_abs, win_count, e_cnt); end
    start_scenario();
    for (int i = 0; i < 5; i++) drive(24'sd5000, 1'b1, 1'b0);
    drive(24'sd777777, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) drive(24'(hf[i]), 1'b1, 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL clear_concurrent_early: got %0d pulses expected 0", obs_q.size()); end
    drive(24'(hf[16]), 1'b1, 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != 1 || win_sum !== -32'sd1 || win_max !== 24'sd1920)
      begin errors++; $display("FAIL clear_concurrent_values: got %0d pulses sum=%0d max=%0d expected 1 -1 1920", obs_q.size(), win_sum, win_max); end
  endtask

  task automatic test_async_reset();
    start_scenario();
    for (int i = 0; i < 6; i++) drive(24'(hf[i]), 1'b1, 1'b0);
    sample_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    win_samples.delete();
    {e_sum, e_abs, e_max, e_min, e_det, e_cnt} = '0;
    checks++;
    if ({win_sum, win_abs, win_max, win_min, result_valid, detect, win_count} !== '0)
      begin errors++; $display("FAIL async_reset_outputs: got sum=%0d abs=%0d cnt=%0d det=%b expected all 0", win_sum, win_abs, win_count, detect); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) drive(24'(hf[i]), 1'b1, 1'b0);
    idle(2);
    checks++;
    if (obs_q.size() != 1 || win_count !== 16'd1 || win_sum !== -32'sd1)
      begin errors++; $display("FAIL async_reset_window: got %0d pulses cnt=%0d sum=%0d expected 1 1 -1", obs_q.size(), win_count, win_sum); end
  endtask

  task automatic test_random();
    logic signed [23:0] x;
    logic v, c;
    int mode;
    start_scenario();
    for (int n = 0; n < 600; n++) begin
      mode = int'($urandom_range(0, 9));
      if (mode == 0) x = 24'h800000;
      else if (mode < 4) x = 24'($urandom);
      else x = 24'(int'($urandom_range(0, 8000)) - 4000);
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 59) == 0);
      drive(x, v, c);
    end
    idle(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_pulse_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] != exp_q[i]) begin errors++; $display("FAIL rand_pulse_cycle[%0d]: got %0d expected %0d", i, obs_q[i], exp_q[i]); end
      end
    end
    checks++;
    if ({win_sum, win_abs, win_max, win_min, detect, win_count} !== {e_sum, e_abs, e_max, e_min, e_det, e_cnt})
      begin errors++; $display("FAIL rand_values: got sum=%0d abs=%0d max=%0d min=%0d det=%b cnt=%0d expected %0d %0d %0d %0d %b %0d",
        win_sum, win_abs, win_max, win_min, detect, win_count, e_sum, e_abs, e_max, e_min, e_det, e_cnt); end
  endtask

  initial begin
    test_reset();
    test_hf_pattern();
    test_gap();
    test_back_to_back();
    test_extremes();
    test_clear();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
